// File: rtl/audio_sink_pkg.sv
// -----------------------------------------------------------------------------
// audio_sink_pkg
// Shared types and helpers for the audio PWM sink.
//   SAMPLE_W          : width of one audio sample (16 bits)
//   sample_t          : signed two's-complement sample
//   to_offset_binary  : maps a signed sample onto 0..65535 for the modulator
// -----------------------------------------------------------------------------
package audio_sink_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Flipping the sign bit moves -32768..32767 onto 0..65535,
    // so zero lands at mid-scale (0x8000).
    function automatic logic [SAMPLE_W-1:0] to_offset_binary(input sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_sink_fifo.sv
// -----------------------------------------------------------------------------
// audio_sink_fifo
// Small sample buffer between the stream source and the sample-rate pacer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push_i      : write data_i this cycle (caller guarantees not_full_o was high)
//   pop_i       : read and discard the head entry (ignored when empty)
//   data_i      : sample to write
//   data_o      : head of queue (valid when empty_o is low)
//   empty_o     : no entries held
//   not_full_o  : registered acknowledge, low once every slot is taken
// DEPTH must be a power of two so the pointers can wrap on their own.
// -----------------------------------------------------------------------------
module audio_sink_fifo
    import audio_sink_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  logic    pop_i,
    input  sample_t data_i,
    output sample_t data_o,
    output logic    empty_o,
    output logic    not_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sample_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ack_q;
    logic               ack_d;
    logic               pop_en;

    assign pop_en     = pop_i && (count_q != '0);
    assign empty_o    = (count_q == '0);
    assign not_full_o = ack_q;
    assign data_o     = mem_q[rd_ptr_q];

    // Next occupancy includes this cycle's push and pop, so a pop at full
    // re-opens the acknowledge on the very next cycle.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ack_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ack_q   <= ack_d;
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage is not cleared on reset; resetting the pointers is enough
    // to discard its contents.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/audio_pwm_sink.sv
// -----------------------------------------------------------------------------
// audio_pwm_sink
// Consumes a stb/ack audio stream, paces samples out at one per SAMPLE_DIVIDE
// clocks and turns them into a 1-bit first-order delta-sigma stream.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   input_audio      : [15:0] signed sample, [31:16] ignored
//   input_audio_stb  : source has a word
//   input_audio_ack  : sink can take a word (transfer on stb && ack)
//   audio_pwm        : registered delta-sigma bitstream
//   audio_sd         : amplifier enable, set by the first sample played
//   underrun         : one-cycle pulse when a sample tick finds no data
// Build option:
//   AUDIO_PWM_SINK_HOLD_EN defined   -> repeat last sample on underrun
//   AUDIO_PWM_SINK_HOLD_EN undefined -> play mid-scale silence on underrun
// -----------------------------------------------------------------------------
module audio_pwm_sink
    import audio_sink_pkg::*;
#(
    parameter int SAMPLE_DIVIDE = 2083,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_audio,
    input  logic        input_audio_stb,
    output logic        input_audio_ack,
    output logic        audio_pwm,
    output logic        audio_sd,
    output logic        underrun
);

    localparam int                CNT_W     = $clog2(SAMPLE_DIVIDE);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(SAMPLE_DIVIDE - 1);

    logic [CNT_W-1:0]    tick_cnt_q;
    logic [CNT_W-1:0]    tick_cnt_d;
    logic                tick;
    sample_t             cur_sample_q;
    sample_t             cur_sample_d;
    logic                sd_q;
    logic                sd_d;
    logic [SAMPLE_W-1:0] acc_q;
    logic                carry_q;
    logic                pwm_q;
    logic [SAMPLE_W:0]   sum;
    logic                push;
    logic                fifo_empty;
    logic                fifo_not_full;
    sample_t             fifo_data;
    logic                unused_upper;

    assign unused_upper = ^input_audio[31:16];

    assign push = input_audio_stb && fifo_not_full;

    audio_sink_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (tick),
        .data_i     (input_audio[SAMPLE_W-1:0]),
        .data_o     (fifo_data),
        .empty_o    (fifo_empty),
        .not_full_o (fifo_not_full)
    );

    // Sample pacing: one tick on the last count of every period. On a tick
    // the head sample is loaded, or the underrun policy applies if empty.
    always_comb begin
        tick         = (tick_cnt_q == TICK_LAST);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);
        cur_sample_d = cur_sample_q;
        sd_d         = sd_q;
        if (tick) begin
            if (!fifo_empty) begin
                cur_sample_d = fifo_data;
                sd_d         = 1'b1;
            end else begin
`ifdef AUDIO_PWM_SINK_HOLD_EN
                cur_sample_d = cur_sample_q;
`else
                cur_sample_d = '0;
`endif
            end
        end
    end

    // First-order delta-sigma: the accumulator overflow is the output bit,
    // so the long-run density of ones equals the offset-binary sample.
    assign sum = {1'b0, acc_q} + {1'b0, to_offset_binary(cur_sample_q)};

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            cur_sample_q <= '0;
            sd_q         <= 1'b0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            pwm_q        <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            cur_sample_q <= cur_sample_d;
            sd_q         <= sd_d;
            acc_q        <= sum[SAMPLE_W-1:0];
            carry_q      <= sum[SAMPLE_W];
            pwm_q        <= carry_q;
        end
    end

    assign input_audio_ack = fifo_not_full;
    assign audio_pwm       = pwm_q;
    assign audio_sd        = sd_q;
    assign underrun        = tick && fifo_empty && !rst;

endmodule
